pdm_capture_ctrl: RTL and testbench
===================================

# pdm_capture_ctrl

Sequencer for the PDM microphone front end: gates the PDM clock generator on and off, holds off capture for a microphone wake-up interval, then deserialises the 1-bit PDM stream into fixed-width words. It sits between the PDM clock generator (whose 1-cycle rising-edge strobe it consumes) and the decimation filter, which takes the words over a valid/ready handshake.

## Interface
- WORD_W, 16, bits per output word; must be ≥ 2.
- WAKE_CYCLES, 3072, mic-clock rising edges discarded after enable (about 1 ms at 3.072 MHz); must be ≥ 1.
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  1-cycle request to begin capture; honoured only in IDLE.
- stop  in  1  1-cycle request to end capture; honoured in WAKE and CAPTURE.
- m_clk_rising  in  1  1-cycle strobe from the clock generator at each mic-clock rising edge.
- pdm_data  in  1  microphone data, already synchronised to clk.
- clk_en  out  1  enable for the PDM clock generator.
- busy  out  1  high whenever state ≠ IDLE.
- capturing  out  1  high in CAPTURE.
- word_data  out  WORD_W  deserialised word; the first-captured bit is the MSB.
- word_valid  out  1  word_data holds an unconsumed word.
- word_ready  in  1  consumer accepts the word when word_valid & word_ready.
- overflow  out  1  sticky: a completed word was dropped.
- overflow_clr  in  1  clears overflow.

## Operation
- States: IDLE, WAKE, CAPTURE, DRAIN. Reset → IDLE. All outputs and counters reset to 0.
- IDLE: clk_en = 0. start → WAKE, wake counter cleared.
- WAKE: clk_en = 1. Each strobe increments the wake counter, which is $clog2(WAKE_CYCLES+1) bits wide. The strobe that brings the count to WAKE_CYCLES moves the FSM to CAPTURE with bit_cnt = 0. pdm_data is ignored in WAKE. stop → IDLE.
- CAPTURE: clk_en = 1.
  - On each strobe, shift = {shift[WORD_W-2:0], pdm_data} and bit_cnt increments.
  - On the strobe where bit_cnt = WORD_W-1:
    - word_data ← {shift[WORD_W-2:0], pdm_data};
    - word_valid ← 1;
    - bit_cnt ← 0 (wraps).
  - stop → DRAIN. The partial word is discarded and bit_cnt and shift are cleared.
- DRAIN: clk_en = 0. Stay until word_valid = 0 (the pending word is consumed), then go to IDLE. If word_valid is already 0 on entry, go to IDLE on the next cycle.
- Handshake:
  - word_valid clears the cycle after word_valid & word_ready.
  - word_data is stable while word_valid = 1 and the word has not been accepted.
- Completion collision:
  - If a word completes while word_valid = 1 and word_ready = 0, the new word is dropped, the old word is kept, and overflow ← 1.
  - If word_ready = 1 in the same cycle, the new word loads, word_valid stays 1, and there is no overflow.
- overflow: set has priority over overflow_clr in the same cycle. Cleared only by overflow_clr or rst.
- Priorities:
  - stop in the same cycle as a strobe: stop wins. The bit is not captured, and no word completes or wake edge is counted.
  - start outside IDLE is ignored.
  - stop in IDLE or DRAIN is ignored.
  - start and stop together in IDLE: start is taken.
- rst mid-operation: immediately IDLE, clk_en = 0, and any pending word is lost (word_valid = 0).

## Timing
- start at cycle t → busy = 1 and clk_en = 1 at t+1.
- First captured bit: the strobe after the WAKE_CYCLES-th wake strobe.
- word_valid rises the cycle after the strobe carrying bit WORD_W-1. That is 1 cycle of latency from the last bit.
- stop at cycle t:
  - state DRAIN or IDLE at t+1;
  - clk_en = 0 at t+1;
  - capturing = 0 at t+1.
- All outputs are registered, with no combinational paths from inputs to outputs.
- The clock generator keeps its own phase; this block only gates it via clk_en.

## Test plan
- Parameters for all tests: WORD_W = 16, WAKE_CYCLES = 4, strobe every 16 clk, word_ready = 1.
- Wake hold-off and alignment: start, then drive pdm_data = 1 during the 4 wake strobes and 0xA5C3 MSB-first afterwards → word_data = 0xA5C3, word_valid high for exactly 1 cycle, clk_en high from the cycle after start.
- Back-pressure overflow: word_ready = 0, capture two words 0x1234 then 0xFFFF → word_data stays 0x1234 and overflow = 1. Then word_ready = 1 → word accepted, word_valid = 0. overflow_clr → overflow = 0.
- Accept on completion: word_ready pulsed high in the exact cycle the second word completes → second word loaded, word_valid stays 1, overflow = 0.
- Stop mid-word: stop after 7 bits of a word → DRAIN then IDLE, no word_valid, clk_en = 0. A new start then yields a correctly aligned word after 4 wake strobes.
- Stop with a pending word: word_ready = 0 and word pending, stop → state held in DRAIN (busy = 1, clk_en = 0) until word_ready = 1, then IDLE. Also: stop coincident with the 16th strobe → no word produced.
- Async reset in CAPTURE with word_valid = 1 → all outputs 0 immediately; start after reset behaves as in the first test.

Source files
------------

// File: rtl/pdm_capture_ctrl.sv
// PDM microphone capture sequencer: gates the mic clock, waits out the wake-up
// interval, then deserialises pdm_data (MSB first) into words for a valid/ready sink.
module pdm_capture_ctrl #(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned WAKE_CYCLES = 3072
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              m_clk_rising,
  input  logic              pdm_data,
  output logic              clk_en,
  output logic              busy,
  output logic              capturing,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int unsigned CNT_W  = $clog2(WORD_W);
  localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAKE, CAPTURE, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   word_data_q, word_data_d;
  logic                word_valid_q, word_valid_d;
  logic                overflow_q, overflow_d;
  logic                clk_en_q, clk_en_d;
  logic                busy_q, busy_d;
  logic                capturing_q, capturing_d;
  logic [WORD_W-1:0]   new_word;

  always_comb begin
    state_d      = state_q;
    wake_cnt_d   = wake_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    overflow_d   = overflow_q;
    new_word     = {shift_q, pdm_data};

    if (word_valid_q && word_ready) word_valid_d = 1'b0;
    if (overflow_clr)               overflow_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (m_clk_rising) begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
          if (wake_cnt_q == WAKE_LAST) begin
            state_d   = CAPTURE;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
      end
      CAPTURE: begin
        if (stop) begin
          state_d   = DRAIN;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else if (m_clk_rising) begin
          shift_d = new_word[WORD_W-2:0];
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            // A completed word is kept only if the slot is free or is being emptied now.
            if (word_valid_q && !word_ready) begin
              overflow_d = 1'b1;
            end else begin
              word_data_d  = new_word;
              word_valid_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!word_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    clk_en_d    = (state_d == WAKE) || (state_d == CAPTURE);
    busy_d      = (state_d != IDLE);
    capturing_d = (state_d == CAPTURE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wake_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      clk_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      capturing_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wake_cnt_q   <= wake_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
      clk_en_q     <= clk_en_d;
      busy_q       <= busy_d;
      capturing_q  <= capturing_d;
    end
  end

  assign clk_en     = clk_en_q;
  assign busy       = busy_q;
  assign capturing  = capturing_q;
  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Scoreboard bench for pdm_capture_ctrl: expected words are queued as they are
// driven and compared when the sink accepts them.
module tb_pdm_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        m_clk_rising = 1'b0;
  logic        pdm_data = 1'b0;
  logic        clk_en;
  logic        busy;
  logic        capturing;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        overflow;
  logic        overflow_clr = 1'b0;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] exp_q[$];

  pdm_capture_ctrl #(.WORD_W(16), .WAKE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .m_clk_rising(m_clk_rising), .pdm_data(pdm_data),
    .clk_en(clk_en), .busy(busy), .capturing(capturing),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One mic-clock period: 15 idle cycles then a strobe cycle carrying bit b.
  task automatic send_bit(input logic b, input logic rdy_pulse, input logic stop_pulse);
    repeat (15) tick();
    pdm_data     = b;
    m_clk_rising = 1'b1;
    if (rdy_pulse)  word_ready = 1'b1;
    if (stop_pulse) stop = 1'b1;
    tick();
    m_clk_rising = 1'b0;
    stop         = 1'b0;
    if (rdy_pulse) word_ready = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic rdy_last, input logic stop_last);
    for (int i = 15; i >= 0; i--)
      send_bit(w[i], (i == 0) && rdy_last, (i == 0) && stop_last);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wake_ones();
    repeat (4) send_bit(1'b1, 1'b0, 1'b0);
  endtask

  // Sink side: every accepted word is matched against the oldest expected word.
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", 32'(exp_q.size()), 32'd1);
      else                   check("word", 32'(word_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    check("rst_clk_en", 32'(clk_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_capturing", 32'(capturing), 0);
    check("rst_valid", 32'(word_valid), 0);
    check("rst_data", 32'(word_data), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    word_ready = 1'b1;
    tick();

    // Wake hold-off and alignment
    do_start();
    check("start_clk_en", 32'(clk_en), 1);
    check("start_busy", 32'(busy), 1);
    check("start_capturing", 32'(capturing), 0);
    wake_ones();
    check("wake_done_capturing", 32'(capturing), 1);
    check("wake_no_valid", 32'(word_valid), 0);
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 1'b0, 1'b0);
    check("t1_valid_rise", 32'(word_valid), 1);
    check("t1_data", 32'(word_data), 32'h0000_A5C3);
    tick();
    check("t1_valid_one_cycle", 32'(word_valid), 0);

    // Back-pressure overflow
    word_ready = 1'b0;
    exp_q.push_back(16'h1234);
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'hFFFF, 1'b0, 1'b0);
    check("ovf_data_kept", 32'(word_data), 32'h0000_1234);
    check("ovf_valid", 32'(word_valid), 1);
    check("ovf_set", 32'(overflow), 1);
    word_ready = 1'b1;
    tick();
    check("ovf_accepted", 32'(word_valid), 0);
    check("ovf_sticky", 32'(overflow), 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);

    // Accept in the same cycle a new word completes
    word_ready = 1'b0;
    exp_q.push_back(16'h0F0F);
    send_word(16'h0F0F, 1'b0, 1'b0);
    exp_q.push_back(16'h3C96);
    send_word(16'h3C96, 1'b1, 1'b0);
    check("coll_valid", 32'(word_valid), 1);
    check("coll_data", 32'(word_data), 32'h0000_3C96);
    check("coll_no_ovf", 32'(overflow), 0);
    word_ready = 1'b1;
    tick();
    check("coll_accepted", 32'(word_valid), 0);

    // Stop mid-word, then restart
    repeat (7) send_bit(1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stopmid_busy", 32'(busy), 1);
    check("stopmid_clk_en", 32'(clk_en), 0);
    check("stopmid_capturing", 32'(capturing), 0);
    tick();
    check("stopmid_idle", 32'(busy), 0);
    check("stopmid_no_valid", 32'(word_valid), 0);
    do_start();
    wake_ones();
    exp_q.push_back(16'h5AA5);
    send_word(16'h5AA5, 1'b0, 1'b0);
    check("restart_data", 32'(word_data), 32'h0000_5AA5);
    tick();

    // Stop with a pending word
    word_ready = 1'b0;
    exp_q.push_back(16'h8001);
    send_word(16'h8001, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("drain_busy", 32'(busy), 1);
    check("drain_clk_en", 32'(clk_en), 0);
    repeat (5) tick();
    check("drain_held", 32'(busy), 1);
    check("drain_valid_held", 32'(word_valid), 1);
    word_ready = 1'b1;
    tick();
    check("drain_accepted", 32'(word_valid), 0);
    check("drain_still_busy", 32'(busy), 1);
    tick();
    check("drain_to_idle", 32'(busy), 0);

    // Stop coincident with the last strobe of a word
    do_start();
    wake_ones();
    send_word(16'hC0DE, 1'b0, 1'b1);
    check("stop16_no_valid", 32'(word_valid), 0);
    check("stop16_clk_en", 32'(clk_en), 0);
    tick();
    check("stop16_idle", 32'(busy), 0);

    // Asynchronous reset with a pending word
    do_start();
    wake_ones();
    word_ready = 1'b0;
    exp_q.push_back(16'h7E81);
    send_word(16'h7E81, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(word_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("arst_valid", 32'(word_valid), 0);
    check("arst_clk_en", 32'(clk_en), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_capturing", 32'(capturing), 0);
    check("arst_data", 32'(word_data), 0);
    tick();
    rst = 1'b0;
    word_ready = 1'b1;
    tick();
    do_start();
    check("post_rst_clk_en", 32'(clk_en), 1);
    wake_ones();
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 1'b0, 1'b0);
    check("post_rst_data", 32'(word_data), 32'h0000_A5C3);
    tick();
    check("post_rst_valid_one_cycle", 32'(word_valid), 0);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
